rr_fu_arbiter: RTL

//  Round-robin arbiter sharing one functional-unit issue port among N requesters (RS entries).

---
 rtl/rr_fu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_fu_arbiter.sv
// Round-robin arbiter sharing one functional-unit issue port among N reservation-station entries.
// Grant is registered one-hot and held across FU back-pressure; the binary index comes from rr_fu_enc.

module rr_fu_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

module rr_fu_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 fu_ready,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 fire,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  cand_idle;
  logic [N-1:0]  cand_fire;
  logic          found_idle;
  logic          found_fire;

  // First set bit of v scanning from p upward with explicit modulo-N wrap; bit N flags "found".
  function automatic logic [N:0] pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [N:0]    res;
    logic [IW-1:0] jj;
    int            j;
    res = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!res[N] && v[jj]) begin
        res[jj] = 1'b1;
        res[N]  = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  rr_fu_enc #(.WIDTH(N), .IDX_W(IW)) u_enc (
    .onehot (gnt),
    .idx    (gnt_idx)
  );

  always_comb begin
    ptr_next                 = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    {found_idle, cand_idle}  = pick(req, ptr);
    // The requester just served is masked so the others get their turn first.
    {found_fire, cand_fire}  = pick(req & ~gnt, ptr_next);
  end

  // A handshake coinciding with reset is discarded, so it is not reported either.
  assign fire = gnt_valid & fu_ready & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found_idle) begin
            gnt       <= cand_idle;
            gnt_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (fu_ready) begin
            ptr <= ptr_next;
            if (found_fire) begin
              gnt <= cand_fire;
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            stall_cnt <= sat_inc(stall_cnt);
            if (!req[gnt_idx]) begin
              if (found_idle) begin
                gnt <= cand_idle;
              end else begin
                gnt       <= '0;
                gnt_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
